// File: rtl/hnf_txrsp.sv
// HNF TX response channel: posq FIFO -> CHI TXRSP link with L-credits; 2-cycle write->FLITV, ready = ~full.
// Optional HNF_TXRSP_LCRD_RETURN_EN: return held credits as RespLCrdReturn flits while deactivating.

package hnf_txrsp_pkg;

  typedef struct packed {
    logic [3:0]  qos;
    logic [10:0] tgtid;
    logic [10:0] srcid;
    logic [11:0] txnid;
    logic [4:0]  opcode;
    logic [1:0]  resperr;
    logic [2:0]  resp;
    logic [2:0]  fwdstate;
    logic [11:0] dbid;
    logic [3:0]  pcrdtype;
    logic        tracetag;
  } rspflit_t;

  localparam logic [4:0] RSP_OPC_LCRDRETURN = 5'h00;

endpackage

module hnf_txrsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_dat = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone defines which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

module hnf_txrsp
  import hnf_txrsp_pkg::*;
#(
  parameter int POSQ_DEPTH = 4,
  parameter int MAX_LCRD   = 15
) (
  input  logic     clock,
  input  logic     reset,
  input  rspflit_t txrsp_posq_entry,
  input  logic     txrsp_posq_entry_valid,
  output logic     txrsp_posq_entry_ready,
  input  logic     link_en,
  output logic     TXLINKACTIVEREQ,
  input  logic     TXLINKACTIVEACK,
  output rspflit_t TXRSPFLIT,
  output logic     TXRSPFLITV,
  output logic     TXRSPFLITPEND,
  input  logic     TXRSPLCRDV,
  output logic     lcrd_overflow
);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_ACTIVATE,
    ST_RUN,
    ST_DEACTIVATE
  } link_state_e;

  localparam logic [3:0] LCRD_MAX = 4'(MAX_LCRD);

  link_state_e state_q;
  logic        req_q;
  logic [3:0]  credit_q, credit_d;
  logic        ovf_q, ovf_d;
  logic        flitv_q, flitv_d;
  rspflit_t    flit_q, flit_d;

  logic     fifo_full, fifo_empty, fifo_push;
  rspflit_t fifo_head;
  logic     send, lcrd_ret, flit_go, lcrd_inc, deact_done, credit_clr;

  assign fifo_push              = txrsp_posq_entry_valid & ~fifo_full;
  assign txrsp_posq_entry_ready = ~fifo_full;

  hnf_txrsp_fifo #(
    .WIDTH ($bits(rspflit_t)),
    .DEPTH (POSQ_DEPTH)
  ) u_posq (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (txrsp_posq_entry),
    .pop      (send),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign send     = (state_q == ST_RUN) && !fifo_empty && (credit_q != 4'd0);
  assign lcrd_inc = TXRSPLCRDV && ((state_q == ST_ACTIVATE) || (state_q == ST_RUN));

`ifdef HNF_TXRSP_LCRD_RETURN_EN
  // Held credits drain as return flits; the link may only stop once none remain.
  assign lcrd_ret   = (state_q == ST_DEACTIVATE) && (credit_q != 4'd0);
  assign deact_done = (credit_q == 4'd0);
  assign credit_clr = 1'b0;
`else
  assign lcrd_ret   = 1'b0;
  assign deact_done = 1'b1;
  assign credit_clr = (state_q == ST_RUN) && !link_en;
`endif

  assign flit_go       = send | lcrd_ret;
  assign TXRSPFLITPEND = flit_go;

  always_comb begin
    credit_d = credit_q;
    ovf_d    = ovf_q;
    if (lcrd_inc && !flit_go) begin
      if (credit_q == LCRD_MAX) ovf_d = 1'b1;
      else                      credit_d = credit_q + 4'd1;
    end else if (flit_go && !lcrd_inc) begin
      credit_d = credit_q - 4'd1;
    end
    if (credit_clr) credit_d = 4'd0;
  end

  always_comb begin
    flitv_d = flit_go;
    flit_d  = flit_q;
    if (send) begin
      flit_d = fifo_head;
    end else if (lcrd_ret) begin
      flit_d        = '0;
      flit_d.opcode = RSP_OPC_LCRDRETURN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      credit_q <= 4'd0;
      ovf_q    <= 1'b0;
      flitv_q  <= 1'b0;
      flit_q   <= '0;
    end else begin
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
      flitv_q  <= flitv_d;
      flit_q   <= flit_d;
    end
  end

  // Link FSM; REQ is registered alongside the state so it is high exactly in ACTIVATE/RUN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_STOP;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_STOP: begin
          if (link_en) begin
            state_q <= ST_ACTIVATE;
            req_q   <= 1'b1;
          end
        end
        ST_ACTIVATE: begin
          if (TXLINKACTIVEACK) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!link_en) begin
            state_q <= ST_DEACTIVATE;
            req_q   <= 1'b0;
          end
        end
        ST_DEACTIVATE: begin
          if (!TXLINKACTIVEACK && deact_done) state_q <= ST_STOP;
        end
        default: begin
          state_q <= ST_STOP;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign TXLINKACTIVEREQ = req_q;
  assign TXRSPFLITV      = flitv_q;
  assign TXRSPFLIT       = flit_q;
  assign lcrd_overflow   = ovf_q;

endmodule

// File: tb/tb_hnf_txrsp.sv
// Randomized + directed bench for hnf_txrsp against a queue-based link/credit reference model.
module tb_hnf_txrsp;
  import hnf_txrsp_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXL  = 15;
`ifdef HNF_TXRSP_LCRD_RETURN_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  logic     clock = 1'b0;
  logic     reset = 1'b0;
  rspflit_t entry;
  logic     vld, ready, link_en, req, ack, lcrdv, flitv, pend, ovf;
  rspflit_t flit;

  hnf_txrsp #(.POSQ_DEPTH(DEPTH), .MAX_LCRD(MAXL)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .txrsp_posq_entry       (entry),
    .txrsp_posq_entry_valid (vld),
    .txrsp_posq_entry_ready (ready),
    .link_en                (link_en),
    .TXLINKACTIVEREQ        (req),
    .TXLINKACTIVEACK        (ack),
    .TXRSPFLIT              (flit),
    .TXRSPFLITV             (flitv),
    .TXRSPFLITPEND          (pend),
    .TXRSPLCRDV             (lcrdv),
    .lcrd_overflow          (ovf)
  );

  always #5 clock = ~clock;

  typedef enum {M_STOP, M_ACT, M_RUN, M_DEACT} mlink_e;
  mlink_e   m_st;
  rspflit_t m_q[$];
  int       m_cred;
  bit       m_ovf;
  bit       m_v;
  rspflit_t m_flit;

  int n_checks = 0;
  int n_errors = 0;
  int flits_seen = 0;
  int ack_cnt = 0;
  int base;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic rspflit_t rand_flit();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return rspflit_t'(r[$bits(rspflit_t)-1:0]);
  endfunction

  // One clock: check PEND/ready against the model, advance the model at the edge, check registered outputs.
  task automatic step();
    bit snd, ret, inc, dec, can_push, pend_now;
    snd      = (m_st == M_RUN) && (m_q.size() > 0) && (m_cred > 0);
    ret      = RET_EN && (m_st == M_DEACT) && (m_cred > 0);
    can_push = m_q.size() < DEPTH;
    pend_now = pend;
    chk("pend", pend, snd || ret);
    chk("ready", ready, can_push);
    @(posedge clock);
    inc = lcrdv && (m_st == M_ACT || m_st == M_RUN);
    dec = snd || ret;
    m_v = dec;
    if (snd)      m_flit = m_q.pop_front();
    else if (ret) m_flit = '0;
    if (vld && can_push) m_q.push_back(entry);
    if (inc && !dec && m_cred == MAXL) m_ovf = 1'b1;
    if (!RET_EN && m_st == M_RUN && !link_en) m_cred = 0;
    else if (inc && !dec && m_cred < MAXL)    m_cred++;
    else if (dec && !inc)                     m_cred--;
    if (m_st == M_STOP && link_en)                               m_st = M_ACT;
    else if (m_st == M_ACT && ack)                               m_st = M_RUN;
    else if (m_st == M_RUN && !link_en)                          m_st = M_DEACT;
    else if (m_st == M_DEACT && !ack && (!RET_EN || m_cred == 0)) m_st = M_STOP;
    #1;
    chk("flitv", flitv, m_v);
    chk("flit", flit, m_flit);
    chk("req", req, (m_st == M_ACT) || (m_st == M_RUN));
    chk("ovf", ovf, m_ovf);
    chk("credit", dut.credit_q, m_cred);
    if (flitv) begin
      flits_seen++;
      chk("pend_lead", pend_now, 1'b1);
    end
    if (ack != req) begin
      if (ack_cnt == 0) begin
        ack     = req;
        ack_cnt = $urandom_range(0, 2);
      end else begin
        ack_cnt--;
      end
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    vld     = 1'b0;
    lcrdv   = 1'b0;
    link_en = 1'b0;
    ack     = 1'b0;
    ack_cnt = 0;
    m_q.delete();
    m_st   = M_STOP;
    m_cred = 0;
    m_ovf  = 1'b0;
    m_v    = 1'b0;
    m_flit = '0;
    #1;
    chk("rst_flitv", flitv, 1'b0);
    chk("rst_pend", pend, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_flit", flit, 0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_credit", dut.credit_q, 0);
    @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  task automatic link_up();
    link_en = 1'b1;
    for (int i = 0; i < 20 && m_st != M_RUN; i++) step();
    chk("link_up_timeout", m_st == M_RUN, 1'b1);
  endtask

  task automatic push_one();
    entry = rand_flit();
    vld   = 1'b1;
    step();
    vld   = 1'b0;
  endtask

  task automatic lcrd_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      lcrdv = 1'b1;
      step();
    end
    lcrdv = 1'b0;
  endtask

  initial begin
    vld = 1'b0; lcrdv = 1'b0; link_en = 1'b0; ack = 1'b0; entry = '0;
    do_reset();

    // Credits offered while stopped must be ignored.
    lcrd_pulses(2);
    chk("stop_ignores_lcrd", dut.credit_q, 0);

    // Two credits, three flits: two back-to-back, third waits for a credit.
    link_up();
    lcrd_pulses(2);
    base = flits_seen;
    for (int i = 0; i < 3; i++) push_one();
    for (int i = 0; i < 6; i++) step();
    chk("t1_two_sent", flits_seen - base, 2);
    lcrd_pulses(1);
    for (int i = 0; i < 4; i++) step();
    chk("t1_third_sent", flits_seen - base, 3);

    // Five pushes with no credit into a four-deep queue.
    base = flits_seen;
    for (int i = 0; i < 5; i++) begin
      push_one();
      if (i == 3) chk("t2_full_after_4", ready, 1'b0);
    end
    chk("t2_still_full", ready, 1'b0);
    lcrd_pulses(5);
    for (int i = 0; i < 8; i++) step();
    chk("t2_only_4_sent", flits_seen - base, 4);

    // Saturate credits and overflow by one.
    lcrd_pulses(MAXL + 1);
    chk("t3_credit_sat", dut.credit_q, MAXL);
    chk("t3_overflow", ovf, 1'b1);

    // Credit arrival coincident with a send leaves the count unchanged.
    do_reset();
    link_up();
    lcrd_pulses(3);
    push_one();
    lcrdv = 1'b1;
    step();
    lcrdv = 1'b0;
    chk("t4_credit_same", dut.credit_q, 3);
    step();

    // Link down holding three credits.
    base = flits_seen;
    link_en = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("t5_flits", flits_seen - base, RET_EN ? 3 : 0);
    chk("t5_credit", dut.credit_q, 0);
    chk("t5_req", req, 1'b0);
    chk("t5_stopped", m_st == M_STOP, 1'b1);

    // Reset in the FLITV cycle with a flit still queued.
    link_up();
    lcrd_pulses(1);
    push_one();
    push_one();
    for (int i = 0; i < 10 && !flitv; i++) step();
    chk("t6_flitv_seen", flitv, 1'b1);
    do_reset();
    base = flits_seen;
    link_up();
    lcrd_pulses(2);
    for (int i = 0; i < 6; i++) step();
    chk("t6_no_stale", flits_seen - base, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) link_en = ~link_en;
      vld   = $urandom_range(0, 1) == 1;
      entry = rand_flit();
      if (m_st == M_RUN || m_st == M_ACT) lcrdv = $urandom_range(0, 2) == 0;
      else if (m_st == M_STOP)            lcrdv = $urandom_range(0, 1) == 1;
      else                                lcrdv = 1'b0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
